// File: rtl/fetch_unit_multicycle_if.sv
// Instruction-memory read port of the fetch unit: req/addr out, ack/rdata back.
// The master side is the fetch unit; the slave side is the instruction memory.
interface fetch_unit_multicycle_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit_multicycle.sv
// Instruction-fetch stage for the multicycle RISC core.
// Owns the program counter and instruction register, and runs a req/ack
// handshake to instruction memory when the control unit pulses IR_enable.
// Optional feature macro FETCH_TIMEOUT_EN: bounds the memory wait to TIMEOUT
// cycles; on expiry the instruction register is cleared and the sticky
// fetch_error flag is raised. Without the macro the wait is unbounded and
// fetch_error is tied low.
module fetch_unit_multicycle #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter int                TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    IR_enable,
    input  logic                    PC_enable,
    input  logic                    branch,
    input  logic                    jump,
    input  logic                    branch_cond,
    fetch_unit_multicycle_if.master imem,
    output logic [INSTR_W-1:0]      instr,
    output logic [4:0]              opcode,
    output logic [ADDR_W-1:0]       pc,
    output logic                    fetch_busy,
    output logic                    fetch_error
);

    // Parameter sanity: the opcode slice needs 32-bit instructions, the jump
    // target and the 32-bit sign extension need ADDR_W within INSTR_W and 32,
    // and the timeout counter is 8 bits.
    generate
        if (INSTR_W < 32 || ADDR_W < 1 || ADDR_W > 32 || ADDR_W > INSTR_W ||
            TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
            $error("fetch_unit_multicycle: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_next_s;
    logic [ADDR_W-1:0]  branch_off_s;
    logic [INSTR_W-1:0] instr_r;
    logic               imem_req_r;
    logic [ADDR_W-1:0]  imem_addr_r;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    logic [7:0]         timeout_cnt_r;
    logic               fetch_error_r;
`endif

    // Next PC: only an IDLE-cycle PC_enable moves the PC; jump beats a taken branch.
    always_comb begin
        pc_next_s    = pc_r;
        branch_off_s = ADDR_W'({{16{instr_r[15]}}, instr_r[15:0]});
        if (state_r == ST_IDLE && PC_enable) begin
            if (jump) begin
                pc_next_s = instr_r[ADDR_W-1:0];
            end else if (branch && branch_cond) begin
                pc_next_s = pc_r + PC_ONE + branch_off_s;
            end else begin
                pc_next_s = pc_r + PC_ONE;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Fetch FSM, PC/IR registers and memory request; the fetch address is the
    // PC after this edge's update so a same-cycle PC_enable+IR_enable fetches
    // the new instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= {INSTR_W{1'b0}};
            imem_req_r    <= 1'b0;
            imem_addr_r   <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
            timeout_cnt_r <= 8'd0;
            fetch_error_r <= 1'b0;
`endif
        end else begin
            pc_r <= pc_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (IR_enable) begin
                        state_r       <= ST_REQ;
                        imem_req_r    <= 1'b1;
                        imem_addr_r   <= pc_next_s;
`ifdef FETCH_TIMEOUT_EN
                        timeout_cnt_r <= 8'd0;
`endif
                    end else begin
                        state_r    <= ST_IDLE;
                        imem_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        instr_r    <= imem.imem_rdata;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_IDLE;
`ifdef FETCH_TIMEOUT_EN
                    end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                        instr_r       <= {INSTR_W{1'b0}};
                        fetch_error_r <= 1'b1;
                        imem_req_r    <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                    end
`else
                    end else begin
                        state_r <= ST_REQ;
                    end
`endif
                end
                default: begin
                    state_r    <= ST_IDLE;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so the control unit holds FETCH in the request cycle.
    assign fetch_busy = (state_r == ST_REQ) || (state_r == ST_IDLE && IR_enable);

    assign imem.imem_req  = imem_req_r;
    assign imem.imem_addr = imem_addr_r;
    assign instr          = instr_r;
    assign opcode         = instr_r[INSTR_W-1 -: 5];
    assign pc             = pc_r;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_error    = fetch_error_r;
`else
    assign fetch_error    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit_multicycle.sv
// Self-checking bench for fetch_unit_multicycle: directed steps from the test
// plan followed by randomized fetch/PC-update traffic, all checked against a
// behavioural model that tracks PC, IR and the error flag as plain integers.
module tb_fetch_unit_multicycle;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;
`ifdef FETCH_TIMEOUT_EN
    localparam int TMO = 3;
`else
    localparam int TMO = 15;
`endif
    localparam int WS = (TMO > 4) ? 4 : TMO - 1;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               IR_enable, PC_enable, branch, jump, branch_cond;
    logic [INSTR_W-1:0] instr;
    logic [4:0]         opcode;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_busy, fetch_error;

    fetch_unit_multicycle_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

    fetch_unit_multicycle #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .IR_enable(IR_enable), .PC_enable(PC_enable),
        .branch(branch), .jump(jump), .branch_cond(branch_cond),
        .imem(imem_bus.master),
        .instr(instr), .opcode(opcode), .pc(pc),
        .fetch_busy(fetch_busy), .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          m_pc;
    logic [31:0] m_instr;
    logic        m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec rule: jump absolute, taken branch pc+1+sext(imm16), else pc+1, mod 2^16.
    function automatic int next_pc(int cur, logic [31:0] ins, logic j, logic b, logic c);
        int off;
        if (j) return int'(ins[15:0]);
        if (b && c) begin
            off = ins[15] ? int'(ins[15:0]) - 65536 : int'(ins[15:0]);
            return (cur + 1 + off + 65536) % 65536;
        end
        return (cur + 1) % 65536;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_pc"},     64'(pc),                 64'(m_pc));
        chk({tag, "_instr"},  64'(instr),              64'(m_instr));
        chk({tag, "_opcode"}, 64'(opcode),             64'(m_instr[31:27]));
        chk({tag, "_req"},    64'(imem_bus.imem_req),  64'(0));
        chk({tag, "_busy"},   64'(fetch_busy),         64'(0));
        chk({tag, "_err"},    64'(fetch_error),        64'(m_err));
    endtask

    task automatic pc_step(input logic j, input logic b, input logic c);
        PC_enable = 1'b1; jump = j; branch = b; branch_cond = c;
        #1 chk("busy_pc_only", 64'(fetch_busy), 64'(0));
        tick();
        PC_enable = 1'b0; jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        m_pc = next_pc(m_pc, m_instr, j, b, c);
        chk("pc_update", 64'(pc), 64'(m_pc));
    endtask

    task automatic fetch(input logic [31:0] word, input int waits,
                         input logic pce, input logic j, input logic b, input logic c);
        IR_enable = 1'b1; PC_enable = pce; jump = j; branch = b; branch_cond = c;
        #1 chk("busy_request_cycle", 64'(fetch_busy), 64'(1));
        tick();
        if (pce) m_pc = next_pc(m_pc, m_instr, j, b, c);
        for (int k = 0; k < waits; k++) begin
            IR_enable   = 1'($urandom_range(0, 1));
            PC_enable   = 1'($urandom_range(0, 1));
            jump        = 1'($urandom_range(0, 1));
            branch      = 1'($urandom_range(0, 1));
            branch_cond = 1'($urandom_range(0, 1));
            imem_bus.imem_rdata = $urandom;
            #1;
            chk("wait_req",  64'(imem_bus.imem_req),  64'(1));
            chk("wait_addr", 64'(imem_bus.imem_addr), 64'(m_pc));
            chk("wait_busy", 64'(fetch_busy),         64'(1));
            chk("wait_pc",   64'(pc),                 64'(m_pc));
            tick();
        end
        IR_enable = 1'b0; PC_enable = 1'b0; jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = word;
        #1;
        chk("ack_req",  64'(imem_bus.imem_req),  64'(1));
        chk("ack_addr", 64'(imem_bus.imem_addr), 64'(m_pc));
        chk("ack_busy", 64'(fetch_busy),         64'(1));
        tick();
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = $urandom;
        m_instr = word;
        idle_checks("after_fetch");
    endtask

    task automatic set_pc(input int target);
        fetch(32'(target), 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc_step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; IR_enable = 1'b0; PC_enable = 1'b0;
        jump = 1'b0; branch = 1'b0; branch_cond = 1'b0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
        m_pc = 0; m_instr = 32'h0; m_err = 1'b0;

        // Reset state, before any clock edge.
        #3;
        idle_checks("reset");
        chk("reset_addr", 64'(imem_bus.imem_addr), 64'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // First fetch, ack in the first REQ cycle.
        fetch(32'h4800_0003, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_opcode", 64'(opcode), 64'(5'b01001));

        // Wait states with ignored pulses during REQ.
        fetch(32'hA5A5_1234, WS, 1'b0, 1'b0, 1'b0, 1'b0);

        // Taken branch, negative offset, from pc=10.
        set_pc(10);
        fetch(32'h1234_FFFC, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc_step(1'b0, 1'b1, 1'b1);
        chk("branch_taken", 64'(pc), 64'(7));

        // Not-taken branch from pc=10.
        set_pc(10);
        fetch(32'h0000_FFFC, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc_step(1'b0, 1'b1, 1'b0);
        chk("branch_not_taken", 64'(pc), 64'(11));

        // Jump has priority over branch.
        fetch(32'h0000_0040, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        pc_step(1'b1, 1'b1, 1'b1);
        chk("jump_priority", 64'(pc), 64'(16'h0040));

        // Increment wraps at all-ones.
        set_pc(16'hFFFF);
        pc_step(1'b0, 1'b0, 1'b0);
        chk("pc_wrap", 64'(pc), 64'(0));

        // Same-cycle PC_enable and IR_enable: fetch uses the updated PC.
        set_pc(5);
        IR_enable = 1'b1; PC_enable = 1'b1;
        tick();
        IR_enable = 1'b0; PC_enable = 1'b0;
        m_pc = 6;
        chk("same_cycle_addr", 64'(imem_bus.imem_addr), 64'(6));
        chk("same_cycle_pc",   64'(pc),                 64'(6));
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1357_9BDF;
        tick();
        imem_bus.imem_ack = 1'b0;
        m_instr = 32'h1357_9BDF;
        idle_checks("same_cycle_done");

        // Stray ack while IDLE leaves instr alone.
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_ack = 1'b0;
        idle_checks("idle_ack");

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0)
                pc_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                fetch($urandom, int'($urandom_range(0, TMO - 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef FETCH_TIMEOUT_EN
        // No ack: request drops after TMO REQ cycles, IR cleared, error sticky.
        IR_enable = 1'b1;
        tick();
        IR_enable = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            chk("timeout_req_held", 64'(imem_bus.imem_req), 64'(1));
            chk("timeout_err_low",  64'(fetch_error),       64'(0));
            tick();
        end
        m_instr = 32'h0; m_err = 1'b1;
        idle_checks("timeout");
        fetch(32'h2468_ACE0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("error_sticky", 64'(fetch_error), 64'(1));
`endif

        // Reset mid-REQ drops the request without a clock edge.
        IR_enable = 1'b1;
        tick();
        IR_enable = 1'b0;
        chk("pre_reset_req", 64'(imem_bus.imem_req), 64'(1));
        #2 reset_n = 1'b0;
        #1 chk("async_reset_req", 64'(imem_bus.imem_req), 64'(0));
        m_pc = 0; m_instr = 32'h0; m_err = 1'b0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        reset_n = 1'b1;
        tick();
        imem_bus.imem_ack = 1'b0;
        idle_checks("late_ack_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_unit_multicycle.md
# fetch_unit_multicycle

Instruction-fetch stage for the multicycle RISC core. It sits directly upstream of the multicycle control unit. It owns the program counter and the instruction register, and runs a req/ack handshake to instruction memory when the control unit pulses `IR_enable`. It presents the fetched opcode back to the control unit and updates the PC on `PC_enable` using that unit's `branch`/`jump` outputs.

## Interface
Parameters:
- `ADDR_W`, 16: PC and instruction-memory word-address width.
- `INSTR_W`, 32: instruction width. Must be at least 32.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: maximum cycles to wait for `imem_ack`. Used only with `FETCH_TIMEOUT_EN`. Range 1..255.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `IR_enable`, in, 1: fetch request pulse from the control unit.
- `PC_enable`, in, 1: PC update pulse from the control unit.
- `branch`, in, 1: branch instruction in execute.
- `jump`, in, 1: jump instruction in execute.
- `branch_cond`, in, 1: branch condition from the datapath (BEQ/BNE result already resolved).
- `imem_req`, out, 1: memory read request.
- `imem_addr`, out, `ADDR_W`: memory word address. Stable while `imem_req` is high.
- `imem_ack`, in, 1: read-data-valid strobe.
- `imem_rdata`, in, `INSTR_W`: read data. Sampled only when `imem_ack` is high.
- `instr`, out, `INSTR_W`: instruction register.
- `opcode`, out, 5: `instr[INSTR_W-1:INSTR_W-5]`. Feeds the control unit.
- `pc`, out, `ADDR_W`: address of the instruction held in `instr`.
- `fetch_busy`, out, 1: the control unit must hold in FETCH while this is high.
- `fetch_error`, out, 1: sticky fetch timeout flag.

## Operation
State machine: IDLE, REQ.

- **Reset values:** state IDLE, `pc`=`RESET_PC`, `instr`=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_busy`=0, `fetch_error`=0, timeout counter 0.
- **IDLE → REQ:** taken when `IR_enable`=1. At that edge `imem_addr` is loaded with the PC value in effect after this edge's PC update.
- **REQ behaviour:** `imem_req`=1 and `imem_addr` is held.
  - On `imem_ack`=1: `instr` ← `imem_rdata`, then → IDLE.
- **`fetch_busy`:** equals (state==REQ) OR (state==IDLE AND `IR_enable`). This is combinational, so the control unit sees the stall in the same cycle it requests.
- **PC update:** applied on `PC_enable`=1 in IDLE only. Priority, highest first:
  - `jump`=1: `pc` ← `instr[ADDR_W-1:0]` (absolute target).
  - `branch`=1 and `branch_cond`=1: `pc` ← `pc` + 1 + sign-extended `instr[15:0]`, truncated to `ADDR_W`.
  - Otherwise: `pc` ← `pc` + 1.
- **Arithmetic:** modulo 2^`ADDR_W`. `pc` = all-ones increments to 0. Negative offsets wrap.
- **`IR_enable` and `PC_enable` in the same IDLE cycle:** the PC update happens first, and the fetch uses the updated PC.
- **`IR_enable` or `PC_enable` while in REQ:** ignored, with no state change.
- **`imem_ack` while in IDLE:** ignored. `instr` is unchanged.
- **Reset asserted mid-REQ:** `imem_req` drops asynchronously. A later `imem_ack` is ignored.

## Timing
- Minimum fetch latency: `IR_enable` at cycle 0, `imem_req` high in cycle 1.
  - If `imem_ack` arrives in cycle 1, `instr`/`opcode` are valid and `fetch_busy`=0 in cycle 2.
- Each cycle of memory wait adds one cycle.
- The PC update is visible on `pc` the cycle after `PC_enable`.
- All outputs are registered except `fetch_busy` and `opcode`. `opcode` is a slice of a register.

## Configuration
Macro: `FETCH_TIMEOUT_EN`.

- **Defined:**
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - If the counter reaches `TIMEOUT` without ack: `instr` ← 0, `fetch_error` ← 1 (sticky until reset), then → IDLE.
  - If ack arrives in the expiry cycle, ack wins and no error is flagged.
- **Undefined:** REQ waits indefinitely, `fetch_error` is tied 0, and no counter is built.

## Test plan
- **Reset and first fetch:** release `reset_n`, pulse `IR_enable`, ack in the first REQ cycle with `imem_rdata`=0x4800_0003 → `imem_addr`=0, `instr`=0x4800_0003, `opcode`=5'b01001 two cycles after the pulse, `fetch_busy` low in that cycle.
- **Wait states:** ack delayed 4 cycles → `imem_req` and `imem_addr` stable for 5 cycles, `fetch_busy` high throughout; `IR_enable`/`PC_enable` pulses during the wait leave `pc` unchanged.
- **Branches, `pc`=10:**
  - `branch`=1, `branch_cond`=1, `instr[15:0]`=0xFFFC, `PC_enable` → `pc`=7.
  - Same with `branch_cond`=0 → `pc`=11.
- **Jump and wrap:**
  - `jump`=1 with `branch`=1, `instr[15:0]`=0x0040 → `pc`=0x0040 (jump priority).
  - `pc`=0xFFFF with plain `PC_enable` → `pc`=0x0000.
- **Same-cycle pulses:** `pc`=5, `PC_enable` and `IR_enable` together → `imem_addr`=6 in REQ.
- **Timeout (with `FETCH_TIMEOUT_EN`, `TIMEOUT`=3) and reset mid-REQ:**
  - No ack → after 3 REQ cycles `imem_req`=0, `instr`=0, `fetch_error`=1, and it stays set.
  - Asserting `reset_n`=0 mid-REQ drops `imem_req` with no clock edge.
